// File: rtl/vec_pkg.sv
// Shared types and constants for the vector operand sequencer.
package vec_pkg;

    localparam int ELEM_W = 32;
    localparam int VREG_W = 5;

    typedef enum logic [3:0] {
        OP_VADD = 4'h0,
        OP_VMUL = 4'h1
    } op_e;

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/vec_issue_if.sv
// Instruction handshake, VRF read port and FU issue lanes of vec_issue.
interface vec_issue_if #(
    parameter int ADD_NUM = 1,
    parameter int MUL_NUM = 1,
    parameter int IDX_W   = 5
) ();
    localparam int L = vec_pkg::max_int(ADD_NUM, MUL_NUM);
    localparam int EW = vec_pkg::ELEM_W;
    localparam int RW = vec_pkg::VREG_W;

    logic                   in_valid;
    logic                   in_ready;
    logic [3:0]             in_op;
    logic [RW-1:0]          in_vs1;
    logic [RW-1:0]          in_vs2;
    logic [IDX_W:0]         in_vl;

    logic                   rd_en;
    logic [RW-1:0]          rd_vs1;
    logic [RW-1:0]          rd_vs2;
    logic [IDX_W-1:0]       rd_idx;
    logic [L*EW-1:0]        rd_data_a;
    logic [L*EW-1:0]        rd_data_b;

    logic [ADD_NUM*EW-1:0]  a_add;
    logic [ADD_NUM*EW-1:0]  b_add;
    logic [ADD_NUM-1:0]     add_vld;
    logic [MUL_NUM*EW-1:0]  a_mul;
    logic [MUL_NUM*EW-1:0]  b_mul;
    logic [MUL_NUM-1:0]     mul_vld;
    logic                   done;
    logic                   err;

    modport master (
        output in_valid, in_op, in_vs1, in_vs2, in_vl, rd_data_a, rd_data_b,
        input  in_ready, rd_en, rd_vs1, rd_vs2, rd_idx,
        input  a_add, b_add, add_vld, a_mul, b_mul, mul_vld, done, err
    );

    modport slave (
        input  in_valid, in_op, in_vs1, in_vs2, in_vl, rd_data_a, rd_data_b,
        output in_ready, rd_en, rd_vs1, rd_vs2, rd_idx,
        output a_add, b_add, add_vld, a_mul, b_mul, mul_vld, done, err
    );

endinterface

// File: rtl/vec_lane_mask.sv
// Per-lane valid mask for one element group: lane k is live when k < remaining and k < lane_num.
module vec_lane_mask #(
    parameter int LANES = 1,
    parameter int CNT_W = 6
) (
    input  logic [CNT_W-1:0] remaining,
    input  logic [CNT_W-1:0] lane_num,
    output logic [LANES-1:0] mask
);

    // Build the mask lane by lane.
    always_comb begin
        mask = '0;
        for (int k = 0; k < LANES; k++) begin
            if ((CNT_W'(k) < remaining) && (CNT_W'(k) < lane_num)) begin
                mask[k] = 1'b1;
            end else begin
                mask[k] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/vec_issue.sv
// vec_issue: reads VRF element pairs and issues them group-wise to the adder or multiplier lanes.
// Define VEC_ISSUE_PERF_EN to add saturating perf_elems / perf_instrs counters.
module vec_issue
    import vec_pkg::*;
#(
    parameter int ADD_NUM = 1,
    parameter int MUL_NUM = 1,
    parameter int VLMAX   = 32,
    parameter int IDX_W   = 5
) (
    input  logic       clk,
    input  logic       rst,
    vec_issue_if.slave bus
`ifdef VEC_ISSUE_PERF_EN
    ,
    output logic [31:0] perf_elems,
    output logic [15:0] perf_instrs
`endif
);
    localparam int L     = max_int(ADD_NUM, MUL_NUM);
    localparam int CNT_W = IDX_W + 1;

    state_e              state_r, state_s;
    logic                start_s, last_s;
    logic                accept_s, legal_s, new_mul_s;
    logic [CNT_W-1:0]    vl_clamp_s, step_s, rem_next_s;
    logic [CNT_W-1:0]    rem_r, n_r;
    logic                is_mul_r;
    logic                in_ready_r, rd_en_r;
    logic [IDX_W-1:0]    rd_idx_r;
    logic [VREG_W-1:0]   rd_vs1_r, rd_vs2_r;
    logic [L-1:0]        mask_s, p_mask_r;
    logic                p_vld_r, p_mul_r, p_last_r;

    logic [ADD_NUM*ELEM_W-1:0] a_add_s, b_add_s, a_add_r, b_add_r;
    logic [ADD_NUM-1:0]        add_vld_s, add_vld_r;
    logic [MUL_NUM*ELEM_W-1:0] a_mul_s, b_mul_s, a_mul_r, b_mul_r;
    logic [MUL_NUM-1:0]        mul_vld_s, mul_vld_r;
    logic                      done_s, err_s, done_r, err_r;

    // Instruction decode and per-group countdown arithmetic.
    always_comb begin
        accept_s  = bus.in_valid & in_ready_r;
        legal_s   = (bus.in_op == OP_VADD) || (bus.in_op == OP_VMUL);
        new_mul_s = (bus.in_op == OP_VMUL);
        if (bus.in_vl > CNT_W'(VLMAX)) begin
            vl_clamp_s = CNT_W'(VLMAX);
        end else begin
            vl_clamp_s = bus.in_vl;
        end
        if (rem_r < n_r) begin
            step_s = rem_r;
        end else begin
            step_s = n_r;
        end
        rem_next_s = rem_r - step_s;
    end

    // Next-state logic: READ lasts one cycle per element group.
    always_comb begin
        state_s = state_r;
        start_s = 1'b0;
        last_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (accept_s && legal_s && (vl_clamp_s != {CNT_W{1'b0}})) begin
                    state_s = READ;
                    start_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            READ: begin
                if (rem_next_s == {CNT_W{1'b0}}) begin
                    state_s = IDLE;
                    last_s  = 1'b1;
                end else begin
                    state_s = READ;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State register, latched instruction and VRF read port.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            in_ready_r <= 1'b0;
            rd_en_r    <= 1'b0;
            rd_idx_r   <= '0;
            rd_vs1_r   <= '0;
            rd_vs2_r   <= '0;
            rem_r      <= '0;
            n_r        <= '0;
            is_mul_r   <= 1'b0;
        end else begin
            state_r    <= state_s;
            in_ready_r <= (state_s == IDLE);
            rd_en_r    <= (state_s == READ);
            if (start_s) begin
                rd_vs1_r <= bus.in_vs1;
                rd_vs2_r <= bus.in_vs2;
                rd_idx_r <= '0;
                rem_r    <= vl_clamp_s;
                n_r      <= new_mul_s ? CNT_W'(MUL_NUM) : CNT_W'(ADD_NUM);
                is_mul_r <= new_mul_s;
            end else if (state_r == READ) begin
                rem_r    <= rem_next_s;
                rd_idx_r <= last_s ? {IDX_W{1'b0}} : (rd_idx_r + IDX_W'(n_r));
            end else begin
                rem_r    <= rem_r;
                rd_idx_r <= rd_idx_r;
            end
        end
    end

    vec_lane_mask #(
        .LANES (L),
        .CNT_W (CNT_W)
    ) u_lane_mask (
        .remaining (rem_r),
        .lane_num  (n_r),
        .mask      (mask_s)
    );

    // Group metadata travels alongside the 1-cycle VRF read latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            p_vld_r  <= 1'b0;
            p_mask_r <= '0;
            p_mul_r  <= 1'b0;
            p_last_r <= 1'b0;
        end else begin
            p_vld_r  <= (state_r == READ);
            p_mask_r <= mask_s;
            p_mul_r  <= is_mul_r;
            p_last_r <= last_s;
        end
    end

    // Route returned data to the selected unit; dead lanes carry zero.
    always_comb begin
        a_add_s   = '0;
        b_add_s   = '0;
        add_vld_s = '0;
        a_mul_s   = '0;
        b_mul_s   = '0;
        mul_vld_s = '0;
        for (int k = 0; k < ADD_NUM; k++) begin
            if (p_vld_r && !p_mul_r && p_mask_r[k]) begin
                add_vld_s[k]                    = 1'b1;
                a_add_s[k*ELEM_W +: ELEM_W]     = bus.rd_data_a[k*ELEM_W +: ELEM_W];
                b_add_s[k*ELEM_W +: ELEM_W]     = bus.rd_data_b[k*ELEM_W +: ELEM_W];
            end else begin
                add_vld_s[k] = 1'b0;
            end
        end
        for (int k = 0; k < MUL_NUM; k++) begin
            if (p_vld_r && p_mul_r && p_mask_r[k]) begin
                mul_vld_s[k]                    = 1'b1;
                a_mul_s[k*ELEM_W +: ELEM_W]     = bus.rd_data_a[k*ELEM_W +: ELEM_W];
                b_mul_s[k*ELEM_W +: ELEM_W]     = bus.rd_data_b[k*ELEM_W +: ELEM_W];
            end else begin
                mul_vld_s[k] = 1'b0;
            end
        end
        // A zero-length done can coincide with the previous instruction's last group; both merge into one pulse.
        done_s = (p_vld_r & p_last_r) | (accept_s & legal_s & (vl_clamp_s == {CNT_W{1'b0}}));
        err_s  = accept_s & ~legal_s;
    end

    // Issue-stage output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_add_r   <= '0;
            b_add_r   <= '0;
            add_vld_r <= '0;
            a_mul_r   <= '0;
            b_mul_r   <= '0;
            mul_vld_r <= '0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            a_add_r   <= a_add_s;
            b_add_r   <= b_add_s;
            add_vld_r <= add_vld_s;
            a_mul_r   <= a_mul_s;
            b_mul_r   <= b_mul_s;
            mul_vld_r <= mul_vld_s;
            done_r    <= done_s;
            err_r     <= err_s;
        end
    end

`ifdef VEC_ISSUE_PERF_EN
    logic [31:0] perf_elems_r;
    logic [15:0] perf_instrs_r;
    logic [32:0] elems_sum_s;

    // Element total before saturation.
    always_comb begin
        elems_sum_s = {1'b0, perf_elems_r} + 33'($countones(add_vld_r)) + 33'($countones(mul_vld_r));
    end

    // Saturating performance counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_elems_r  <= 32'd0;
            perf_instrs_r <= 16'd0;
        end else begin
            perf_elems_r <= elems_sum_s[32] ? 32'hFFFF_FFFF : elems_sum_s[31:0];
            if (done_r && (perf_instrs_r != 16'hFFFF)) begin
                perf_instrs_r <= perf_instrs_r + 16'd1;
            end else begin
                perf_instrs_r <= perf_instrs_r;
            end
        end
    end

    assign perf_elems  = perf_elems_r;
    assign perf_instrs = perf_instrs_r;
`endif

    assign bus.in_ready = in_ready_r;
    assign bus.rd_en    = rd_en_r;
    assign bus.rd_idx   = rd_idx_r;
    assign bus.rd_vs1   = rd_vs1_r;
    assign bus.rd_vs2   = rd_vs2_r;
    assign bus.a_add    = a_add_r;
    assign bus.b_add    = b_add_r;
    assign bus.add_vld  = add_vld_r;
    assign bus.a_mul    = a_mul_r;
    assign bus.b_mul    = b_mul_r;
    assign bus.mul_vld  = mul_vld_r;
    assign bus.done     = done_r;
    assign bus.err      = err_r;

endmodule

// File: tb/tb_vec_issue.sv
// Randomized self-checking bench for vec_issue against a cycle-scheduled element-level model.
module tb_vec_issue;
    import vec_pkg::*;

    localparam int ADD_NUM = 1;
    localparam int MUL_NUM = 4;
    localparam int VLMAX   = 32;
    localparam int IDX_W   = 5;
    localparam int L       = 4;
    localparam int W       = L * 32;

    typedef struct {
        int idx;
        int vs1;
        int vs2;
    } rd_t;

    typedef struct {
        bit           mul;
        logic [L-1:0] vld;
        logic [W-1:0] a;
        logic [W-1:0] b;
    } iss_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   ready_at = 2;

    logic [31:0] vrf [32][32];
    rd_t  exp_rd  [int];
    iss_t exp_iss [int];
    bit   exp_done[int];
    bit   exp_err [int];

    logic       cap_en = 1'b0;
    int         cap_idx = 0;
    int         cap_vs1 = 0;
    int         cap_vs2 = 0;

    always #5 clk = ~clk;

    vec_issue_if #(.ADD_NUM(ADD_NUM), .MUL_NUM(MUL_NUM), .IDX_W(IDX_W)) bus ();

`ifdef VEC_ISSUE_PERF_EN
    logic [31:0] perf_elems;
    logic [15:0] perf_instrs;
    longint      m_elems = 0;
    longint      m_instrs = 0;
`endif

    vec_issue #(
        .ADD_NUM (ADD_NUM),
        .MUL_NUM (MUL_NUM),
        .VLMAX   (VLMAX),
        .IDX_W   (IDX_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef VEC_ISSUE_PERF_EN
        ,
        .perf_elems  (perf_elems),
        .perf_instrs (perf_instrs)
`endif
    );

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // Expected behaviour of one accepted instruction, scheduled by cycle.
    task automatic schedule(input int c, input logic [3:0] op, input int vs1, input int vs2, input int vl_in);
        int   vl, n, groups;
        rd_t  r;
        iss_t is;
        vl = (vl_in > VLMAX) ? VLMAX : vl_in;
        if (op != 4'h0 && op != 4'h1) begin
            exp_err[c+1] = 1'b1;
        end else if (vl == 0) begin
            exp_done[c+1] = 1'b1;
        end else begin
            n = (op == 4'h1) ? MUL_NUM : ADD_NUM;
            groups = (vl + n - 1) / n;
            for (int g = 0; g < groups; g++) begin
                r.idx = g * n; r.vs1 = vs1; r.vs2 = vs2;
                exp_rd[c+1+g] = r;
                is.mul = (op == 4'h1); is.vld = '0; is.a = '0; is.b = '0;
                for (int k = 0; k < n; k++) begin
                    if (g * n + k < vl) begin
                        is.vld[k] = 1'b1;
                        is.a[k*32 +: 32] = vrf[vs1][g*n+k];
                        is.b[k*32 +: 32] = vrf[vs2][g*n+k];
                    end
                end
                exp_iss[c+3+g] = is;
            end
            exp_done[c+2+groups] = 1'b1;
            ready_at = c + 1 + groups;
        end
    endtask

    task automatic check_cycle();
        iss_t is;
        check("in_ready", {127'd0, bus.in_ready}, {127'd0, (cyc >= ready_at)});
        check("rd_en", {127'd0, bus.rd_en}, {127'd0, exp_rd.exists(cyc)});
        if (exp_rd.exists(cyc)) begin
            check("rd_idx", W'(bus.rd_idx), W'(exp_rd[cyc].idx));
            check("rd_vs1", W'(bus.rd_vs1), W'(exp_rd[cyc].vs1));
            check("rd_vs2", W'(bus.rd_vs2), W'(exp_rd[cyc].vs2));
        end
        if (exp_iss.exists(cyc)) begin
            is = exp_iss[cyc];
            if (is.mul) begin
                check("mul_vld", W'(bus.mul_vld), W'(is.vld));
                check("a_mul", W'(bus.a_mul), is.a);
                check("b_mul", W'(bus.b_mul), is.b);
                check("add_vld", W'(bus.add_vld), W'(0));
            end else begin
                check("add_vld", W'(bus.add_vld), W'(is.vld[0]));
                check("a_add", W'(bus.a_add), W'(is.a[31:0]));
                check("b_add", W'(bus.b_add), W'(is.b[31:0]));
                check("mul_vld", W'(bus.mul_vld), W'(0));
            end
        end else begin
            check("add_vld", W'(bus.add_vld), W'(0));
            check("mul_vld", W'(bus.mul_vld), W'(0));
        end
        check("done", {127'd0, bus.done}, {127'd0, exp_done.exists(cyc)});
        check("err", {127'd0, bus.err}, {127'd0, exp_err.exists(cyc)});
`ifdef VEC_ISSUE_PERF_EN
        check("perf_elems", W'(perf_elems), W'(m_elems));
        check("perf_instrs", W'(perf_instrs), W'(m_instrs));
`endif
    endtask

    // One clock cycle: drive inputs, check outputs, advance the model.
    task automatic step(input bit rst_v, input bit vld, input logic [3:0] op,
                        input int vs1, input int vs2, input int vl);
        @(posedge clk);
        cyc++;
        #1;
        rst          = rst_v;
        bus.in_valid = vld;
        bus.in_op    = op;
        bus.in_vs1   = 5'(vs1);
        bus.in_vs2   = 5'(vs2);
        bus.in_vl    = 6'(vl);
        for (int k = 0; k < L; k++) begin
            bus.rd_data_a[k*32 +: 32] = cap_en ? vrf[cap_vs1][(cap_idx + k) % 32] : $urandom;
            bus.rd_data_b[k*32 +: 32] = cap_en ? vrf[cap_vs2][(cap_idx + k) % 32] : $urandom;
        end
        @(negedge clk);
        check_cycle();
`ifdef VEC_ISSUE_PERF_EN
        if (exp_iss.exists(cyc)) m_elems += $countones(exp_iss[cyc].vld);
        if (exp_done.exists(cyc)) m_instrs++;
`endif
        if (rst_v) begin
            exp_rd.delete(); exp_iss.delete(); exp_done.delete(); exp_err.delete();
            ready_at = cyc + 2;
`ifdef VEC_ISSUE_PERF_EN
            m_elems = 0; m_instrs = 0;
`endif
        end else if (vld && cyc >= ready_at) begin
            schedule(cyc, op, vs1, vs2, vl);
        end
        cap_en  = bus.rd_en;
        cap_idx = int'(bus.rd_idx);
        cap_vs1 = int'(bus.rd_vs1);
        cap_vs2 = int'(bus.rd_vs2);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'h0, 0, 0, 0);
    endtask

    initial begin
        int r, op, vl;
        bus.in_valid = 1'b0; bus.in_op = 4'h0; bus.in_vs1 = 5'd0; bus.in_vs2 = 5'd0; bus.in_vl = 6'd0;
        bus.rd_data_a = '0; bus.rd_data_b = '0;
        for (int i = 0; i < 32; i++)
            for (int j = 0; j < 32; j++) vrf[i][j] = $urandom;
        for (int j = 0; j < 3; j++) begin
            vrf[1][j] = 32'(j + 1);
            vrf[2][j] = 32'(10 * (j + 1));
        end

        step(1'b1, 1'b0, 4'h0, 0, 0, 0);
        step(1'b1, 1'b0, 4'h0, 0, 0, 0);
        idle(2);

        step(1'b0, 1'b1, 4'h0, 1, 2, 3);    // VADD vl=3
        idle(6);
        step(1'b0, 1'b1, 4'h1, 3, 4, 6);    // VMUL vl=6
        idle(5);
        step(1'b0, 1'b1, 4'h0, 5, 6, 40);   // clamped to 32 elements
        idle(36);
        step(1'b0, 1'b1, 4'h1, 7, 8, 40);
        idle(12);
        step(1'b0, 1'b1, 4'h7, 1, 2, 5);    // illegal op
        step(1'b0, 1'b1, 4'h0, 0, 0, 0);    // vl=0 right after err
        step(1'b0, 1'b1, 4'h0, 1, 2, 2);    // back-to-back VADD vl=2
        idle(6);
        step(1'b0, 1'b1, 4'h0, 9, 10, 8);   // reset in cycle 4 of this run
        idle(3);
        step(1'b1, 1'b0, 4'h0, 0, 0, 0);
        idle(5);

        for (int i = 0; i < 700; i++) begin
            r = $urandom_range(0, 99);
            op = ($urandom_range(0, 7) < 6) ? $urandom_range(0, 1) : $urandom_range(0, 15);
            vl = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 9);
            if (r == 0) begin
                step(1'b1, 1'b0, 4'h0, 0, 0, 0);
            end else begin
                step(1'b0, (r < 45), 4'(op), $urandom_range(0, 31), $urandom_range(0, 31), vl);
            end
        end
        idle(40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
